// File: rtl/stream_dist_1_4.sv
// Header-framed stream distributor: one 32-bit ap_vld/ap_ack input, four outputs.
// Payload goes to one selected output or is broadcast to all four via per-output FIFOs.
module stream_dist_1_4 #(
    parameter int unsigned DATA_BITS      = 32,
    parameter int unsigned OUT_FIFO_DEPTH = 4,
    parameter int unsigned LEN_BITS       = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_start,
    output logic                 ap_idle,
    input  logic [DATA_BITS-1:0] Input_1_V_V,
    input  logic                 Input_1_V_V_ap_vld,
    output logic                 Input_1_V_V_ap_ack,
    output logic [DATA_BITS-1:0] Output_1_V_V,
    output logic                 Output_1_V_V_ap_vld,
    input  logic                 Output_1_V_V_ap_ack,
    output logic [DATA_BITS-1:0] Output_2_V_V,
    output logic                 Output_2_V_V_ap_vld,
    input  logic                 Output_2_V_V_ap_ack,
    output logic [DATA_BITS-1:0] Output_3_V_V,
    output logic                 Output_3_V_V_ap_vld,
    input  logic                 Output_3_V_V_ap_ack,
    output logic [DATA_BITS-1:0] Output_4_V_V,
    output logic                 Output_4_V_V_ap_vld,
    input  logic                 Output_4_V_V_ap_ack,
    output logic [15:0]          frame_count
);

    localparam int unsigned AW = $clog2(OUT_FIFO_DEPTH);

    typedef enum logic {HDR, PAY} state_t;

    state_t              state;
    logic [1:0]          dest;
    logic                bcast;
    logic [LEN_BITS-1:0] rem;

    logic [DATA_BITS-1:0] mem [4][OUT_FIFO_DEPTH];
    logic [AW:0]          wptr [4];
    logic [AW:0]          rptr [4];
    logic [DATA_BITS-1:0] head [4];

    logic [3:0] empty, full, target, push, pop, out_ack;
    logic       in_xfer;

    assign out_ack = {Output_4_V_V_ap_ack, Output_3_V_V_ap_ack,
                      Output_2_V_V_ap_ack, Output_1_V_V_ap_ack};

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            empty[k] = (wptr[k] == rptr[k]);
            full[k]  = (wptr[k][AW] != rptr[k][AW]) &&
                       (wptr[k][AW-1:0] == rptr[k][AW-1:0]);
            head[k]  = empty[k] ? '0 : mem[k][rptr[k][AW-1:0]];
        end
    end

    // Broadcast targets all four FIFOs so that ack only rises when every one has space.
    always_comb begin
        target = bcast ? 4'b1111 : (4'b0001 << dest);
        if (ap_rst)
            Input_1_V_V_ap_ack = 1'b0;
        else if (state == HDR)
            Input_1_V_V_ap_ack = ap_start;
        else
            Input_1_V_V_ap_ack = ((target & full) == 4'b0000);
        in_xfer = Input_1_V_V_ap_vld && Input_1_V_V_ap_ack;
        push    = (state == PAY && in_xfer) ? target : 4'b0000;
        pop     = ~empty & out_ack;
    end

    assign ap_idle = (state == HDR) && (&empty);

    assign Output_1_V_V        = head[0];
    assign Output_2_V_V        = head[1];
    assign Output_3_V_V        = head[2];
    assign Output_4_V_V        = head[3];
    assign Output_1_V_V_ap_vld = ~empty[0];
    assign Output_2_V_V_ap_vld = ~empty[1];
    assign Output_3_V_V_ap_vld = ~empty[2];
    assign Output_4_V_V_ap_vld = ~empty[3];

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state       <= HDR;
            dest        <= '0;
            bcast       <= 1'b0;
            rem         <= '0;
            frame_count <= '0;
        end else if (in_xfer) begin
            if (state == HDR) begin
                dest  <= Input_1_V_V[17:16];
                bcast <= Input_1_V_V[18];
                rem   <= Input_1_V_V[LEN_BITS-1:0];
                if (Input_1_V_V[LEN_BITS-1:0] == '0)
                    frame_count <= frame_count + 16'd1;
                else
                    state <= PAY;
            end else begin
                rem <= rem - LEN_BITS'(1);
                if (rem == LEN_BITS'(1)) begin
                    state       <= HDR;
                    frame_count <= frame_count + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int unsigned k = 0; k < 4; k++) begin
                wptr[k] <= '0;
                rptr[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (push[k]) wptr[k] <= wptr[k] + (AW+1)'(1);
                if (pop[k])  rptr[k] <= rptr[k] + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: empty FIFOs present zero on their data outputs.
    always_ff @(posedge ap_clk) begin
        for (int unsigned k = 0; k < 4; k++)
            if (push[k]) mem[k][wptr[k][AW-1:0]] <= Input_1_V_V;
    end

endmodule

// File: tb/tb_stream_dist_1_4.sv
// Bench for stream_dist_1_4: directed scenarios plus random frames checked
// against per-output expected queues built from the framing rules.
module tb_stream_dist_1_4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ap_start = 1'b0;
    logic        idle;
    logic [31:0] in_data = '0;
    logic        in_vld = 1'b0;
    logic        in_ack;
    logic [31:0] odata [4];
    logic [3:0]  ovld;
    logic [3:0]  oack = '0;
    logic [15:0] fc;

    stream_dist_1_4 #(.DATA_BITS(32), .OUT_FIFO_DEPTH(4), .LEN_BITS(16)) dut (
        .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start), .ap_idle(idle),
        .Input_1_V_V(in_data), .Input_1_V_V_ap_vld(in_vld), .Input_1_V_V_ap_ack(in_ack),
        .Output_1_V_V(odata[0]), .Output_1_V_V_ap_vld(ovld[0]), .Output_1_V_V_ap_ack(oack[0]),
        .Output_2_V_V(odata[1]), .Output_2_V_V_ap_vld(ovld[1]), .Output_2_V_V_ap_ack(oack[1]),
        .Output_3_V_V(odata[2]), .Output_3_V_V_ap_vld(ovld[2]), .Output_3_V_V_ap_ack(oack[2]),
        .Output_4_V_V(odata[3]), .Output_4_V_V_ap_vld(ovld[3]), .Output_4_V_V_ap_ack(oack[3]),
        .frame_count(fc)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned ack_mode [4] = '{1, 1, 1, 1};
    int unsigned exp_fc   = 0;
    logic [31:0] got   [4][$];
    logic [31:0] exp_q [4][$];

    // Consumer acks: 0 = low, 1 = high, 2 = random (~70% high)
    initial begin
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++)
                oack[k] = (ack_mode[k] == 2) ? ($urandom_range(0, 99) < 70) : (ack_mode[k] == 1);
        end
    end

    always @(negedge clk)
        if (!rst)
            for (int k = 0; k < 4; k++)
                if (ovld[k] && oack[k]) got[k].push_back(odata[k]);

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [31:0] w, output int unsigned waited);
        bit ok = 1'b0;
        in_data = w;
        in_vld  = 1'b1;
        waited  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ack) begin ok = 1'b1; break; end
            waited++;
        end
        @(posedge clk); #1;
        in_vld = 1'b0;
        if (!ok) check("send_timeout", 64'(ok), 64'd1);
    endtask

    task automatic drain(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 4; k++) ack_mode[k] = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (idle) begin ok = 1'b1; break; end
        end
        check({tag, "_drain"}, 64'(ok), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic compare_outputs(input string tag);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_len_out%0d", tag, k + 1), 64'(got[k].size()), 64'(exp_q[k].size()));
            for (int i = 0; i < exp_q[k].size() && i < got[k].size(); i++)
                check($sformatf("%s_out%0d_word%0d", tag, k + 1, i), 64'(got[k][i]), 64'(exp_q[k][i]));
            got[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_vld%0d", tag, k + 1), 64'(ovld[k]), 64'd0);
            check($sformatf("%s_data%0d", tag, k + 1), 64'(odata[k]), 64'd0);
        end
        check({tag, "_fc"}, 64'(fc), 64'd0);
        check({tag, "_in_ack"}, 64'(in_ack), 64'd0);
        check({tag, "_idle"}, 64'(idle), 64'd1);
    endtask

    initial begin
        int unsigned waited, n;
        logic [1:0]  d;
        bit          b;
        logic [31:0] hdr, pw;

        // Reset: ack must stay low even with start and vld high
        #12;
        ap_start = 1'b1;
        in_vld   = 1'b1;
        #1;
        check_reset_state("reset");
        in_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: unicast to Output_2, one-cycle latency, one word per cycle
        send(32'h0001_0003, waited);
        check("t1_fc_mid", 64'(fc), 64'd0);
        send(32'h0000_000A, waited);
        check("t1_wait_a", 64'(waited), 64'd0);
        check("t1_vld2_a", 64'(ovld[1]), 64'd1);
        check("t1_data2_a", 64'(odata[1]), 64'h0A);
        check("t1_others", 64'({ovld[3], ovld[2], ovld[0]}), 64'd0);
        send(32'h0000_000B, waited);
        check("t1_wait_b", 64'(waited), 64'd0);
        check("t1_data2_b", 64'(odata[1]), 64'h0B);
        send(32'h0000_000C, waited);
        check("t1_wait_c", 64'(waited), 64'd0);
        check("t1_data2_c", 64'(odata[1]), 64'h0C);
        exp_fc = 1;
        check("t1_fc", 64'(fc), 64'(exp_fc));
        exp_q[1] = '{32'h0A, 32'h0B, 32'h0C};
        drain("t1");
        compare_outputs("t1");

        // 2a: broadcast N=2 with Output_3 stalled
        ack_mode[2] = 0;
        @(posedge clk); #1;
        send(32'h0004_0002, waited);
        send(32'h0000_0011, waited);
        send(32'h0000_0022, waited);
        exp_fc++;
        for (int k = 0; k < 4; k++) begin
            exp_q[k].push_back(32'h11);
            exp_q[k].push_back(32'h22);
        end
        drain("t2a");
        compare_outputs("t2a");

        // 2b: broadcast N=6, stall after the fourth word until Output_3 acks
        ack_mode[2] = 0;
        @(posedge clk); #1;
        send(32'h0004_0006, waited);
        for (int i = 1; i <= 4; i++) begin
            send(32'hB0 + 32'(i), waited);
            check($sformatf("t2b_wait_w%0d", i), 64'(waited), 64'd0);
        end
        in_data = 32'hB5;
        in_vld  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t2b_stall%0d", i), 64'(in_ack), 64'd0);
        end
        ack_mode[2] = 1;
        send(32'hB5, waited);
        send(32'hB6, waited);
        exp_fc++;
        for (int k = 0; k < 4; k++)
            for (int i = 1; i <= 6; i++) exp_q[k].push_back(32'hB0 + 32'(i));
        drain("t2b");
        compare_outputs("t2b");
        check("t2_fc", 64'(fc), 64'(exp_fc));

        // 3: zero-length frame counts immediately, next word is a header
        send(32'h0002_0000, waited);
        exp_fc++;
        check("t3_fc", 64'(fc), 64'(exp_fc));
        check("t3_no_vld", 64'(ovld), 64'd0);
        send(32'h0000_0001, waited);
        send(32'h0000_0077, waited);
        exp_fc++;
        exp_q[0].push_back(32'h77);
        drain("t3");
        compare_outputs("t3");
        check("t3_fc2", 64'(fc), 64'(exp_fc));

        // 4: ap_start gates headers only
        ap_start = 1'b0;
        in_data  = 32'h0000_0003;
        in_vld   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t4_ack_low%0d", i), 64'(in_ack), 64'd0);
            check($sformatf("t4_idle%0d", i), 64'(idle), 64'd1);
        end
        @(posedge clk); #1;
        ap_start = 1'b1;
        send(32'h0000_0003, waited);
        check("t4_hdr_wait", 64'(waited), 64'd0);
        ap_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(32'hC0 + 32'(i), waited);
            check($sformatf("t4_pay_wait%0d", i), 64'(waited), 64'd0);
            exp_q[0].push_back(32'hC0 + 32'(i));
        end
        exp_fc++;
        ap_start = 1'b1;
        drain("t4");
        compare_outputs("t4");
        check("t4_fc", 64'(fc), 64'(exp_fc));

        // 5: fill Output_4, then reset asynchronously mid-frame
        ack_mode[3] = 0;
        @(posedge clk); #1;
        send(32'h0003_0008, waited);
        for (int i = 0; i < 4; i++) begin
            send(32'hD0 + 32'(i), waited);
            check($sformatf("t5_wait%0d", i), 64'(waited), 64'd0);
        end
        in_data = 32'hD4;
        in_vld  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t5_full_ack%0d", i), 64'(in_ack), 64'd0);
        end
        check("t5_vld4_before", 64'(ovld[3]), 64'd1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_reset_state("t5_reset");
        in_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ack_mode[3] = 1;
        for (int k = 0; k < 4; k++) begin got[k].delete(); exp_q[k].delete(); end
        exp_fc = 0;
        send(32'h0000_0001, waited);
        send(32'h0000_0099, waited);
        exp_fc++;
        exp_q[0].push_back(32'h99);
        drain("t5");
        compare_outputs("t5");
        check("t5_fc", 64'(fc), 64'(exp_fc));

        // Random frames with random consumer stalls and ap_start toggling mid-frame
        for (int k = 0; k < 4; k++) ack_mode[k] = 2;
        for (int f = 0; f < 40; f++) begin
            n   = $urandom_range(1, 6);
            d   = 2'($urandom_range(0, 3));
            b   = ($urandom_range(0, 3) == 0);
            hdr = {13'($urandom), b, d, 16'(n)};
            ap_start = 1'b1;
            send(hdr, waited);
            for (int i = 0; i < int'(n); i++) begin
                pw = $urandom;
                ap_start = 1'($urandom_range(0, 1));
                send(pw, waited);
                for (int k = 0; k < 4; k++)
                    if (b || d == 2'(k)) exp_q[k].push_back(pw);
                repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            end
            exp_fc++;
        end
        ap_start = 1'b1;
        drain("rand");
        compare_outputs("rand");
        check("rand_fc", 64'(fc), 64'(16'(exp_fc)));

        // 6: frame_count wraps 0xFFFF -> 0
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_data = 32'h0000_0000;
        in_vld  = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        in_vld = 1'b0;
        check("t6_fc_ffff", 64'(fc), 64'hFFFF);
        send(32'h0000_0000, waited);
        check("t6_fc_wrap", 64'(fc), 64'h0000);
        check("t6_idle", 64'(idle), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
